idma_inoc_obuffer_arbiter: RTL

- Arbitrates the single obuffer SRAM port between the NoC receive side, which fills obuffer, and the DMA write engine, which drains obuffer to DDR.
- Mirror of the ibuffer path: the NoC is the writer and the DMA is the reader.
- Phase-based ownership via an FSM, plus an outstanding-read counter so ownership never changes while read responses are in flight.

---
 rtl/idma_inoc_pkg.sv | 18 +
 rtl/idma_inoc_outst_cnt.sv | 52 +++++
 rtl/idma_inoc_obuffer_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/idma_inoc_pkg.sv
// ============================================================================
// idma_inoc_pkg : shared types for the iDMA/NoC obuffer arbitration path
// Rev 1.0
// ============================================================================
`default_nettype none

package idma_inoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_NOC_WRITE = 2'd1,
    ST_DMA_READ  = 2'd2,
    ST_DRAIN     = 2'd3
  } obuf_state_e;

endpackage

`default_nettype wire

// File: rtl/idma_inoc_outst_cnt.sv
// ============================================================================
// idma_inoc_outst_cnt : saturating up/down counter of outstanding reads
// Rev 1.0
// ============================================================================
`default_nettype none

module idma_inoc_outst_cnt
  import idma_inoc_pkg::*;
#(
  parameter int OUTST_W   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [OUTST_W-1:0] cnt_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               underflow_o
);

  localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTST);

  logic [OUTST_W-1:0] cnt_q, cnt_d;

  assign full_o      = (cnt_q >= MAX_CNT);
  assign empty_o     = (cnt_q == '0);
  // Simultaneous inc/dec cancel, so only a lone decrement can underflow.
  assign underflow_o = dec_i & ~inc_i & empty_o;
  assign cnt_o       = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + OUTST_W'(1);
    end else if (dec_i && !inc_i && !empty_o) begin
      cnt_d = cnt_q - OUTST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/idma_inoc_obuffer_arbiter.sv
// ============================================================================
// idma_inoc_obuffer_arbiter : phase-based owner of the obuffer SRAM port
// (NoC fills, DMA drains). Rev 1.0
// ============================================================================
`default_nettype none

module idma_inoc_obuffer_arbiter
  import idma_inoc_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_OUTST  = 4,
  parameter int OUTST_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  noc_write_start,
  input  logic                  noc_write_done,
  input  logic                  dma_read_done,
  input  logic                  noc_write_to_obuffer_cen,
  input  logic                  noc_write_to_obuffer_wen,
  output logic                  noc_write_to_obuffer_ready,
  input  logic [MEM_AW-1:0]     noc_write_to_obuffer_addr,
  input  logic [DATA_WIDTH-1:0] noc_write_to_obuffer_wdata,
  input  logic [STRB_WIDTH-1:0] noc_write_to_obuffer_strb,
  input  logic                  dma_read_from_obuffer_cen,
  input  logic                  dma_read_from_obuffer_wen,
  output logic                  dma_read_from_obuffer_ready,
  input  logic [MEM_AW-1:0]     dma_read_from_obuffer_addr,
  output logic [DATA_WIDTH-1:0] dma_read_from_obuffer_rdata,
  output logic                  dma_read_from_obuffer_rvalid,
  input  logic                  dma_read_from_obuffer_rready,
  output logic                  obuffer_cen,
  output logic                  obuffer_wen,
  input  logic                  obuffer_ready,
  output logic [MEM_AW-1:0]     obuffer_addr,
  output logic [DATA_WIDTH-1:0] obuffer_wdata,
  output logic [STRB_WIDTH-1:0] obuffer_strb,
  input  logic [DATA_WIDTH-1:0] obuffer_rdata,
  input  logic                  obuffer_rvalid,
  output logic                  obuffer_rready,
  output logic                  busy,
  output logic                  protocol_err
);

  obuf_state_e        state_q, state_d;
  logic               start_pend_q, start_pend_d;
  logic               protocol_err_q, protocol_err_d;
  logic [OUTST_W-1:0] outst_cnt;
  logic               cnt_full, cnt_empty, cnt_underflow;
  logic               rsp_phase, rsp_hs, rd_accept, dma_bad_req;

  assign rsp_phase   = (state_q == ST_DMA_READ) || (state_q == ST_DRAIN);
  assign rsp_hs      = obuffer_rvalid & obuffer_rready & rsp_phase;
  assign rd_accept   = (state_q == ST_DMA_READ) & obuffer_cen & obuffer_ready;
  assign dma_bad_req = (state_q == ST_DMA_READ) & dma_read_from_obuffer_cen
                     & dma_read_from_obuffer_wen;

  idma_inoc_outst_cnt #(
    .OUTST_W   (OUTST_W),
    .MAX_OUTST (MAX_OUTST)
  ) u_outst_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (rd_accept),
    .dec_i       (rsp_hs),
    .cnt_o       (outst_cnt),
    .full_o      (cnt_full),
    .empty_o     (cnt_empty),
    .underflow_o (cnt_underflow)
  );

  // Request-side mux: only the phase owner ever reaches the SRAM.
  always_comb begin
    obuffer_cen                 = 1'b0;
    obuffer_wen                 = 1'b0;
    obuffer_addr                = '0;
    obuffer_wdata               = '0;
    obuffer_strb                = '0;
    noc_write_to_obuffer_ready  = 1'b0;
    dma_read_from_obuffer_ready = 1'b0;
    unique case (state_q)
      ST_NOC_WRITE: begin
        obuffer_cen                = noc_write_to_obuffer_cen;
        obuffer_wen                = noc_write_to_obuffer_wen;
        obuffer_addr               = noc_write_to_obuffer_addr;
        obuffer_wdata              = noc_write_to_obuffer_wdata;
        obuffer_strb               = noc_write_to_obuffer_strb;
        noc_write_to_obuffer_ready = obuffer_ready;
      end
      ST_DMA_READ: begin
        obuffer_cen  = dma_read_from_obuffer_cen & ~dma_read_from_obuffer_wen
                     & ~cnt_full;
        obuffer_addr = dma_read_from_obuffer_addr;
        dma_read_from_obuffer_ready = obuffer_ready & ~cnt_full;
      end
      default: ;
    endcase
  end

  assign dma_read_from_obuffer_rdata  = obuffer_rdata;
  assign dma_read_from_obuffer_rvalid = obuffer_rvalid & rsp_phase;
  // Outside the read phases stray responses are sunk; held low in reset.
  assign obuffer_rready = rst_n & (rsp_phase ? dma_read_from_obuffer_rready : 1'b1);

  always_comb begin
    state_d        = state_q;
    start_pend_d   = start_pend_q;
    protocol_err_d = protocol_err_q;

    if ((noc_write_done && state_q != ST_NOC_WRITE) ||
        (dma_read_done && state_q != ST_DMA_READ) ||
        dma_bad_req || cnt_underflow) begin
      protocol_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (noc_write_start) state_d = ST_NOC_WRITE;
      end
      ST_NOC_WRITE: begin
        // Done wins first; a start in the same cycle is then held as pending.
        if (noc_write_done) begin
          state_d = ST_DMA_READ;
          if (noc_write_start) start_pend_d = 1'b1;
        end
      end
      ST_DMA_READ: begin
        if (noc_write_start) start_pend_d = 1'b1;
        if (dma_read_done)   state_d      = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (noc_write_start) start_pend_d = 1'b1;
        if (cnt_empty || (outst_cnt == OUTST_W'(1) && rsp_hs)) begin
          state_d      = (start_pend_q || noc_write_start) ? ST_NOC_WRITE : ST_IDLE;
          start_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      start_pend_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_pend_q   <= start_pend_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign protocol_err = protocol_err_q;

endmodule

`default_nettype wire
